// File: rtl/muldiv_unit_if.sv
// Handshake and data bundle between the pipeline controller and the mul/div unit.
// Latency: n/a (wires only).
// Backpressure: controller holds start until it sees busy low.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output flush, start, op, a, b,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  flush, start, op, a, b,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU (one bit per cycle) owning HI/LO, plus MTHI/MTLO.
// Latency: mul/div result and done pulse WIDTH+2 cycles after accept; MTHI/MTLO visible next cycle.
// Backpressure: start is only taken while busy=0; a request made while busy is dropped, not queued.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   divisor_mag;
    logic               is_div;
    logic               neg_res;
    logic               neg_dvd;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;

    logic               op_muldiv;
    logic               op_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    assign op_muldiv = ~bus.op[2];
    assign op_signed = ~bus.op[0];
    assign a_neg     = op_signed & bus.a[WIDTH-1];
    assign b_neg     = op_signed & bus.b[WIDTH-1];
    assign abs_a     = a_neg ? -bus.a : bus.a;
    assign abs_b     = b_neg ? -bus.b : bus.b;

    // Multiply: prod = {partial, multiplier}; add into the upper half then shift right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, divisor_mag} : '0);
    assign mul_next = {mul_sum, prod[WIDTH-1:1]};

    // Divide: prod = {remainder, quotient/dividend}; restoring trial subtract per bit.
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
    assign div_shift = prod[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, divisor_mag};
    assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], prod[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0],  prod[WIDTH-2:0], 1'b1};

    // Sign fix-up; a zero divisor forces an all-ones quotient, and the remainder
    // re-signed with the dividend's sign reproduces the original dividend.
    logic               b_zero;
    logic [2*WIDTH-1:0] mul_res;
    logic [WIDTH-1:0]   quo_res;
    logic [WIDTH-1:0]   rem_res;
    assign b_zero  = (divisor_mag == '0);
    assign mul_res = neg_res ? -prod : prod;
    assign quo_res = b_zero ? '1 : (neg_res ? -prod[WIDTH-1:0] : prod[WIDTH-1:0]);
    assign rem_res = neg_dvd ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            prod        <= '0;
            divisor_mag <= '0;
            is_div      <= 1'b0;
            neg_res     <= 1'b0;
            neg_dvd     <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.flush) begin
                        if (op_muldiv) begin
                            state       <= CALC;
                            busy_q      <= 1'b1;
                            cnt         <= CNT_W'(WIDTH);
                            prod        <= {{WIDTH{1'b0}}, abs_a};
                            divisor_mag <= abs_b;
                            is_div      <= bus.op[1];
                            neg_res     <= a_neg ^ b_neg;
                            neg_dvd     <= a_neg;
                        end else if (bus.op == OP_MTHI) begin
                            hi_q <= bus.a;
                        end else if (bus.op == OP_MTLO) begin
                            lo_q <= bus.a;
                        end
                    end
                end
                CALC: begin
                    if (bus.flush) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        prod <= is_div ? div_next : mul_next;
                        cnt  <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    if (!bus.flush) begin
                        done_q <= 1'b1;
                        dbz_q  <= is_div & b_zero;
                        if (is_div) begin
                            hi_q <= rem_res;
                            lo_q <= quo_res;
                        end else begin
                            hi_q <= mul_res[2*WIDTH-1:WIDTH];
                            lo_q <= mul_res[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32 and WIDTH=8 with an expected-result queue per instance.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(32)) b32 ();
    muldiv_unit_if #(.WIDTH(8))  b8 ();

    muldiv_unit #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(b32.slave));
    muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(b8.slave));

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t sb32[$];
    exp_t sb8[$];
    int   total = 0;
    int   bad   = 0;

    localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010, DIVU = 3'b011;
    localparam logic [2:0] MTHI = 3'b100, MTLO = 3'b101, RSVD = 3'b110;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit sel, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (sel) begin
            b8.start = 1'b1;  b8.op = op;  b8.a = a[7:0];  b8.b = b[7:0];
        end else begin
            b32.start = 1'b1; b32.op = op; b32.a = a;      b32.b = b;
        end
    endtask

    task automatic issue_md(input bit sel, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
        exp_t e;
        e.hi = ehi; e.lo = elo; e.dbz = edbz;
        if (sel) sb8.push_back(e);
        else     sb32.push_back(e);
        issue(sel, op, a, b);
    endtask

    // Called in the accept cycle; returns in the done cycle.
    task automatic finish(input bit sel, input string tag, input int lat_exp);
        int   n = 0;
        int   nbusy = 0;
        logic dn = 1'b0;
        exp_t e;
        for (int i = 1; i <= 200; i++) begin
            tick();
            n = i;
            if (i == 1) begin
                b32.start = 1'b0;
                b8.start  = 1'b0;
            end
            dn = sel ? b8.done : b32.done;
            if (dn) break;
            if (sel ? b8.busy : b32.busy) nbusy++;
        end
        chk({tag, "_done_seen"}, 64'(dn), 64'(1));
        chk({tag, "_latency"}, 64'(n), 64'(lat_exp));
        chk({tag, "_busy_cycles"}, 64'(nbusy), 64'(lat_exp - 1));
        chk({tag, "_busy_at_done"}, 64'(sel ? b8.busy : b32.busy), 64'(0));
        chk({tag, "_sb_nonempty"}, 64'(sel ? (sb8.size() > 0) : (sb32.size() > 0)), 64'(1));
        if (sel ? (sb8.size() > 0) : (sb32.size() > 0)) begin
            e = sel ? sb8.pop_front() : sb32.pop_front();
            chk({tag, "_hi"}, sel ? 64'(b8.hi) : 64'(b32.hi), 64'(e.hi));
            chk({tag, "_lo"}, sel ? 64'(b8.lo) : 64'(b32.lo), 64'(e.lo));
            chk({tag, "_dbz"}, sel ? 64'(b8.div_by_zero) : 64'(b32.div_by_zero), 64'(e.dbz));
        end
    endtask

    initial begin
        int ndone;
        reset = 1'b1;
        b32.flush = 1'b0; b32.start = 1'b0; b32.op = '0; b32.a = '0; b32.b = '0;
        b8.flush  = 1'b0; b8.start  = 1'b0; b8.op  = '0; b8.a  = '0; b8.b  = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", 64'(b32.busy), 64'(0));
        chk("rst_done", 64'(b32.done), 64'(0));
        chk("rst_dbz", 64'(b32.div_by_zero), 64'(0));
        chk("rst_hilo", {b32.hi, b32.lo}, 64'(0));
        chk("rst_hilo8", 64'({b8.hi, b8.lo}), 64'(0));

        issue_md(0, MULT, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        finish(0, "mult_neg1x2", 34);
        tick();
        chk("done_single_pulse", 64'(b32.done), 64'(0));

        issue_md(0, MULTU, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'hFFFF_FFFE, 1'b0);
        finish(0, "multu", 34);
        issue_md(0, DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        finish(0, "div_b2b_m7d2", 34);

        issue_md(0, DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h3, 1'b0);
        finish(0, "div_m7dm2", 34);
        issue_md(0, DIV, 32'h7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 1'b0);
        finish(0, "div_7dm2", 34);
        issue_md(0, MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
        finish(0, "mult_minxmin", 34);

        issue_md(0, DIVU, 32'h7, 32'h0, 32'h7, 32'hFFFF_FFFF, 1'b1);
        finish(0, "divu_by0", 34);
        issue(0, MTLO, 32'h1234, 32'h0);
        tick();
        b32.start = 1'b0;
        chk("mtlo_lo", 64'(b32.lo), 64'h1234);
        chk("mtlo_hi_kept", 64'(b32.hi), 64'h7);
        chk("mtlo_no_done", 64'(b32.done), 64'(0));
        chk("mtlo_no_busy", 64'(b32.busy), 64'(0));
        chk("mtlo_dbz_held", 64'(b32.div_by_zero), 64'(1));

        issue_md(0, DIV, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
        finish(0, "div_neg_by0", 34);
        issue_md(0, DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        finish(0, "div_ovf", 34);

        tick();
        issue(0, RSVD, 32'h55, 32'h66);
        tick();
        b32.start = 1'b0;
        chk("rsvd_busy", 64'(b32.busy), 64'(0));
        chk("rsvd_hilo", {b32.hi, b32.lo}, 64'h0000_0000_8000_0000);

        issue(0, MTHI, 32'hCAFE, 32'h0);
        tick();
        issue(0, MTLO, 32'hBEEF, 32'h0);
        b32.flush = 1'b1;
        tick();
        b32.flush = 1'b0;
        b32.start = 1'b0;
        chk("flush_idle_drop", {b32.hi, b32.lo}, 64'h0000_CAFE_8000_0000);

        issue(0, MULT, 32'h3, 32'h5);
        ndone = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 1) b32.start = 1'b0;
            if (i == 5) issue(0, MTHI, 32'hDEAD, 32'h0);
            if (i == 6) b32.start = 1'b0;
            if (i == 10) b32.flush = 1'b1;
            if (i == 11) begin
                b32.flush = 1'b0;
                chk("flush_busy", 64'(b32.busy), 64'(0));
            end
            if (b32.done) ndone++;
        end
        chk("flush_no_done", 64'(ndone), 64'(0));
        chk("flush_hilo_kept", {b32.hi, b32.lo}, 64'h0000_CAFE_8000_0000);

        issue(0, DIVU, 32'h100, 32'h3);
        for (int i = 1; i <= 21; i++) begin
            tick();
            if (i == 1) b32.start = 1'b0;
            if (i == 20) reset = 1'b1;
        end
        reset = 1'b0;
        chk("midrst_busy", 64'(b32.busy), 64'(0));
        chk("midrst_done", 64'(b32.done), 64'(0));
        chk("midrst_hilo", {b32.hi, b32.lo}, 64'(0));

        issue_md(1, MULTU, 32'hFF, 32'hFF, 32'hFE, 32'h01, 1'b0);
        finish(1, "w8_multu", 10);
        issue_md(1, DIV, 32'h80, 32'hFF, 32'h00, 32'h80, 1'b0);
        finish(1, "w8_div_ovf", 10);
        issue_md(1, DIV, 32'hF9, 32'h02, 32'hFF, 32'hFD, 1'b0);
        finish(1, "w8_div_m7d2", 10);
        issue_md(1, MULT, 32'h80, 32'h7F, 32'hC0, 32'h80, 1'b0);
        finish(1, "w8_mult_minx127", 10);

        chk("sb32_drained", 64'(sb32.size()), 64'(0));
        chk("sb8_drained", 64'(sb8.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
